// File: rtl/xbar_pkg.sv
// Shared frame geometry, field offsets and helper types for the N-port serial crossbar.
package xbar_pkg;

    localparam int DEF_N_PORTS  = 8;
    localparam int DEF_SLOT_LEN = 16;
    localparam int DEF_ADDR_W   = $clog2(DEF_N_PORTS);

    typedef logic [DEF_ADDR_W-1:0]   port_addr_t;
    typedef logic [DEF_SLOT_LEN-1:0] frame_t;

    // Offsets are bit positions within a slot; position 0 is the first bit on the wire.
    localparam int START_B  = 0;
    localparam int ADDR_LSB = 1;
    localparam int PRIO_B   = ADDR_LSB + DEF_ADDR_W;

    // Maps an in-slot bit position to its index in a fully captured, MSB-first frame vector.
    function automatic int frame_pos(input int slot_len, input int b);
        return slot_len - 1 - b;
    endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter for one crossbar output: search starts at ptr_i, optional priority subset.
module xbar_rr_arb #(
    parameter int N_PORTS = 8
) (
    input  logic [N_PORTS-1:0]         req_i,
    input  logic [N_PORTS-1:0]         prio_i,
    input  logic [$clog2(N_PORTS)-1:0] ptr_i,
    output logic [N_PORTS-1:0]         grant_o,
    output logic [$clog2(N_PORTS)-1:0] winner_o,
    output logic                       valid_o
);
    localparam int ADDR_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0] elig;
    logic [N_PORTS-1:0] rot;
    logic [N_PORTS-1:0] first;

    // When any requester carries the priority flag, only flagged requesters compete.
    assign elig = (|(req_i & prio_i)) ? (req_i & prio_i) : req_i;

    // Rotate so that bit 0 is the input at ptr_i, pick the lowest set bit, rotate back.
    assign rot = N_PORTS'({elig, elig} >> ptr_i);

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_first
        if (gi == 0) begin : g_lsb
            assign first[gi] = rot[gi];
        end else begin : g_rest
            assign first[gi] = rot[gi] & ~(|rot[gi-1:0]);
        end
    end

    assign grant_o = N_PORTS'(({first, first} << ptr_i) >> N_PORTS);
    assign valid_o = |elig;

    for (genvar gb = 0; gb < ADDR_W; gb++) begin : g_enc
        logic [N_PORTS-1:0] hit;
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_bit
            if (((gi >> gb) & 1) == 1) begin : g_on
                assign hit[gi] = grant_o[gi];
            end else begin : g_off
                assign hit[gi] = 1'b0;
            end
        end
        assign winner_o[gb] = |hit;
    end

endmodule

// File: rtl/xbar_nxn_sched.sv
// N-port store-and-forward bit-serial crossbar with independent per-output round-robin scheduling.
// Define XBAR_PRIO_EN to treat frame bit ADDR_W+1 as a priority flag during arbitration.
module xbar_nxn_sched
    import xbar_pkg::*;
#(
    parameter int N_PORTS  = 8,
    parameter int SLOT_LEN = 16,
    parameter int SLOT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PORTS-1:0]  serial_in,
    output logic [N_PORTS-1:0]  serial_out,
    output logic [SLOT_W-1:0]   running_slot,
    output logic                slot_start,
    output logic [N_PORTS-1:0]  header_present,
    output logic [N_PORTS-1:0]  drop_pulse
);
    localparam int ADDR_W    = $clog2(N_PORTS);
    localparam int CNT_W     = $clog2(SLOT_LEN);
    localparam int START_POS = frame_pos(SLOT_LEN, START_B);
    localparam int ADDR_HI   = frame_pos(SLOT_LEN, ADDR_LSB);
    localparam int ADDR_LO   = frame_pos(SLOT_LEN, ADDR_LSB + ADDR_W - 1);

    logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic                            slot_end;
    logic [N_PORTS-1:0]              start_vec;
    logic [N_PORTS-1:0]              prio_vec;
    logic [N_PORTS-1:0]              granted_any;
    logic [N_PORTS-1:0]              drop_q, drop_d;
    logic [SLOT_LEN-1:0]             frame [N_PORTS];
    logic [N_PORTS-1:0]              grant [N_PORTS];
    logic [N_PORTS-1:0][N_PORTS-1:0] grant_t;

    assign slot_end = (bit_cnt_q == CNT_W'(SLOT_LEN - 1));

    always_comb begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        slot_d    = slot_q;
        if (slot_end) begin
            bit_cnt_d = '0;
            slot_d    = slot_q + SLOT_W'(1);
        end
    end

    // Every requester that no output granted is dropped, including out-of-range addresses.
    assign drop_d = slot_end ? (start_vec & ~granted_any) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            slot_q    <= '0;
            drop_q    <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            slot_q    <= slot_d;
            drop_q    <= drop_d;
        end
    end

    assign running_slot = slot_q;
    assign slot_start   = (bit_cnt_q == '0) && !rst;
    assign drop_pulse   = drop_q & ~{N_PORTS{rst}};

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in
        // The oldest captured bit is never needed: the frame is taken the cycle before it would shift out.
        logic [SLOT_LEN-2:0] cap_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cap_q <= '0;
            end else begin
                cap_q <= {cap_q[SLOT_LEN-3:0], serial_in[gi]};
            end
        end

        assign frame[gi]     = {cap_q, serial_in[gi]};
        assign start_vec[gi] = frame[gi][START_POS];
`ifdef XBAR_PRIO_EN
        assign prio_vec[gi]  = frame[gi][frame_pos(SLOT_LEN, ADDR_LSB + ADDR_W)];
`else
        assign prio_vec[gi]  = 1'b0;
`endif

        for (genvar gj = 0; gj < N_PORTS; gj++) begin : g_col
            assign grant_t[gi][gj] = grant[gj][gi];
        end
        assign granted_any[gi] = |grant_t[gi];
    end

    for (genvar gj = 0; gj < N_PORTS; gj++) begin : g_out
        logic [N_PORTS-1:0]  req;
        logic [ADDR_W-1:0]   ptr_q, ptr_d;
        logic [ADDR_W-1:0]   winner;
        logic                valid;
        logic [SLOT_LEN-1:0] pick [N_PORTS+1];
        logic [SLOT_LEN-1:0] out_q;
        logic                hdr_q;

        assign pick[0] = '0;
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_req
            assign req[gi]      = start_vec[gi] && (frame[gi][ADDR_HI:ADDR_LO] == ADDR_W'(gj));
            assign pick[gi + 1] = pick[gi] | (grant[gj][gi] ? frame[gi] : '0);
        end

        xbar_rr_arb #(
            .N_PORTS (N_PORTS)
        ) u_arb (
            .req_i    (req),
            .prio_i   (prio_vec),
            .ptr_i    (ptr_q),
            .grant_o  (grant[gj]),
            .winner_o (winner),
            .valid_o  (valid)
        );

        assign ptr_d = (winner == ADDR_W'(N_PORTS - 1)) ? '0 : winner + ADDR_W'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                ptr_q <= '0;
                out_q <= '0;
                hdr_q <= 1'b0;
            end else if (slot_end) begin
                out_q <= pick[N_PORTS];
                hdr_q <= valid;
                if (valid) begin
                    ptr_q <= ptr_d;
                end
            end else begin
                out_q <= {out_q[SLOT_LEN-2:0], 1'b0};
            end
        end

        assign serial_out[gj]     = out_q[SLOT_LEN-1] & ~rst;
        assign header_present[gj] = hdr_q & ~rst;
    end

endmodule

// File: tb/tb_xbar_nxn_sched.sv
// Directed, table-driven bench for xbar_nxn_sched (8-port instance plus a 6-port instance).
module tb_xbar_nxn_sched;

    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int SL = 16;
    localparam int SW = 8;

    typedef struct packed {
        logic [N-1:0][SL-1:0] frm;   // frame driven on each input this slot
        logic [N-1:0][3:0]    src;   // input expected on each output next slot, 4'hF = none
        logic [N-1:0]         drop;  // drop_pulse expected at bit 0 of next slot
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   serial_in, serial_out, header_present, drop_pulse;
    logic [SW-1:0]  running_slot;
    logic           slot_start;
    logic [N6-1:0]  si6, so6, hp6, dp6;
    logic [SW-1:0]  rs6;
    logic           ss6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xbar_nxn_sched #(.N_PORTS(N), .SLOT_LEN(SL), .SLOT_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .serial_out     (serial_out),
        .running_slot   (running_slot),
        .slot_start     (slot_start),
        .header_present (header_present),
        .drop_pulse     (drop_pulse)
    );

    xbar_nxn_sched #(.N_PORTS(N6), .SLOT_LEN(SL), .SLOT_W(SW)) dut6 (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (si6),
        .serial_out     (so6),
        .running_slot   (rs6),
        .slot_start     (ss6),
        .header_present (hp6),
        .drop_pulse     (dp6)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [SL-1:0] mk(input logic st, input logic [2:0] a, input logic [11:0] p);
        return {st, a, p};
    endfunction

    function automatic vec_t idle_v();
        vec_t v;
        v.frm  = '0;
        v.src  = {N{4'hF}};
        v.drop = '0;
        return v;
    endfunction

    // Drives cur for one slot while checking the outputs produced from prv.
    task automatic run_slot(input vec_t cur, input vec_t prv, input int slot_no);
        logic [N-1:0][SL-1:0] tx, rx_exp;
        logic [N-1:0]         exp_hdr, exp_bit;
        int                   bit_err, hold_err;
        tx = cur.frm;
        for (int j = 0; j < N; j++) begin
            exp_hdr[j] = (prv.src[j] != 4'hF);
            rx_exp[j]  = exp_hdr[j] ? prv.frm[prv.src[j][2:0]] : '0;
        end
        bit_err  = 0;
        hold_err = 0;
        for (int b = 0; b < SL; b++) begin
            for (int i = 0; i < N; i++) begin
                serial_in[i] = tx[i][SL-1];
                tx[i]        = tx[i] << 1;
            end
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                exp_bit[j] = rx_exp[j][SL-1];
                rx_exp[j]  = rx_exp[j] << 1;
            end
            if (serial_out !== exp_bit) bit_err++;
            if (b == 0) begin
                check("slot_start", 32'(slot_start), 32'd1);
                check("running_slot", 32'(running_slot), 32'(slot_no));
                check("header_present", 32'(header_present), 32'(exp_hdr));
                check("drop_pulse", 32'(drop_pulse), 32'(prv.drop));
            end else begin
                if (drop_pulse !== '0 || slot_start !== 1'b0) hold_err++;
            end
            if (header_present !== exp_hdr) hold_err++;
            @(posedge clk);
            #1;
        end
        check("serial_out_bits", 32'(bit_err), 32'd0);
        check("pulse_hold", 32'(hold_err), 32'd0);
        $display("slot %0d: expected hdr=%b drop=%b, seen hdr=%b", slot_no, exp_hdr, prv.drop, header_present);
    endtask

    initial begin
        vec_t         tbl [12];
        vec_t         va, vb, vc;
        logic [SL-1:0] f6 [N6];
        logic [SL-1:0] exp6;
        int           err;

        // ---------------- vector table ----------------
        for (int k = 0; k < 12; k++) tbl[k] = idle_v();
        // single frame: in2 -> out5, payload 0xA5
        tbl[0].frm[2] = mk(1'b1, 3'd5, 12'h0A5);
        tbl[0].src[5] = 4'd2;
        // contention on out1 from in0, in3, in6
        for (int k = 1; k <= 3; k++) begin
            tbl[k].frm[0] = mk(1'b1, 3'd1, 12'h100 + 12'(k));
            tbl[k].frm[3] = mk(1'b1, 3'd1, 12'h130 + 12'(k));
            tbl[k].frm[6] = mk(1'b1, 3'd1, 12'h160 + 12'(k));
        end
        tbl[1].src[1] = 4'd0; tbl[1].drop = 8'b0100_1000;
        tbl[2].src[1] = 4'd3; tbl[2].drop = 8'b0100_0001;
        tbl[3].src[1] = 4'd6; tbl[3].drop = 8'b0000_1001;
        // permutation in[i] -> out[7-i]
        for (int i = 0; i < N; i++) begin
            tbl[4].frm[i] = mk(1'b1, 3'(7 - i), 12'h200 + 12'(i * 17));
            tbl[4].src[i] = 4'(7 - i);
        end
        // start bit clear: nothing forwarded, nothing dropped
        for (int i = 0; i < N; i++) tbl[5].frm[i] = mk(1'b0, 3'(i), 12'hFFF);
        // in1 (prio 0) and in4 (prio 1) both to out2; out2 pointer sits at 6 here
        for (int k = 6; k <= 9; k++) begin
            tbl[k].frm[1] = mk(1'b1, 3'd2, 12'h050 + 12'(k));
            tbl[k].frm[4] = mk(1'b1, 3'd2, 12'h8A0 + 12'(k));
`ifdef XBAR_PRIO_EN
            tbl[k].src[2] = 4'd4;
            tbl[k].drop   = 8'b0000_0010;
`else
            if (k % 2 == 0) begin
                tbl[k].src[2] = 4'd1;
                tbl[k].drop   = 8'b0001_0000;
            end else begin
                tbl[k].src[2] = 4'd4;
                tbl[k].drop   = 8'b0000_0010;
            end
`endif
        end

        // ---------------- reset state ----------------
        serial_in = '1;
        si6       = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial_out", 32'(serial_out), 32'd0);
        check("rst_header", 32'(header_present), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        check("rst_slot_start", 32'(slot_start), 32'd0);
        check("rst_running_slot", 32'(running_slot), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        serial_in = '0;
        si6       = '0;

        for (int k = 0; k < 12; k++) begin
            run_slot(tbl[k], (k == 0) ? idle_v() : tbl[k-1], k);
        end

        // ---------------- 6-port instance: addresses 6 and 7 are illegal ----------------
        f6[0] = mk(1'b0, 3'd5, 12'h777);
        f6[1] = mk(1'b1, 3'd7, 12'h3C3);
        f6[2] = mk(1'b1, 3'd5, 12'h5A5);
        f6[3] = mk(1'b1, 3'd6, 12'h0F0);
        f6[4] = '0;
        f6[5] = '0;
        for (int b = 0; b < SL; b++) begin
            for (int i = 0; i < N6; i++) si6[i] = f6[i][SL-1-b];
            @(posedge clk);
            #1;
        end
        si6  = '0;
        exp6 = f6[2];
        err  = 0;
        for (int b = 0; b < SL; b++) begin
            @(negedge clk);
            if (b == 0) begin
                check("n6_drop", 32'(dp6), 32'b001010);
                check("n6_header", 32'(hp6), 32'b100000);
                check("n6_running_slot", 32'(rs6), 32'd13);
            end
            if (so6 !== {exp6[SL-1], 5'b0}) err++;
            exp6 = exp6 << 1;
            @(posedge clk);
            #1;
        end
        check("n6_serial_out", 32'(err), 32'd0);
        $display("n6 slot 13: expected hdr=100000 drop=001010, seen hdr=%b", hp6);

        // ---------------- reset at bit 7 of slot 3 ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        va = idle_v();
        va.frm[0] = mk(1'b1, 3'd1, 12'h3A5);
        vb = idle_v();
        vb.frm[2] = mk(1'b1, 3'd5, 12'h2B4);
        vc = idle_v();
        vc.frm[0] = mk(1'b1, 3'd1, 12'h111);
        vc.frm[7] = mk(1'b1, 3'd1, 12'h777);
        vc.src[1] = 4'd0;
        vc.drop   = 8'b1000_0000;
        run_slot(idle_v(), idle_v(), 0);
        run_slot(idle_v(), idle_v(), 1);
        run_slot(va, idle_v(), 2);
        err = 0;
        for (int b = 0; b < 7; b++) begin
            serial_in[2] = vb.frm[2][SL-1-b];
            @(negedge clk);
            if (b == 0) begin
                check("pre_rst_header", 32'(header_present), 32'b0000_0010);
                check("pre_rst_running_slot", 32'(running_slot), 32'd3);
            end
            if (serial_out !== {6'b0, va.frm[0][SL-1-b], 1'b0}) err++;
            @(posedge clk);
            #1;
        end
        check("pre_rst_serial_out", 32'(err), 32'd0);
        rst = 1'b1;
        err = 0;
        for (int b = 7; b < 10; b++) begin
            serial_in[2] = vb.frm[2][SL-1-b];
            @(negedge clk);
            if (serial_out !== '0 || header_present !== '0 || drop_pulse !== '0 || slot_start !== 1'b0) err++;
            @(posedge clk);
            #1;
        end
        check("mid_rst_outputs", 32'(err), 32'd0);
        rst       = 1'b0;
        serial_in = '0;
        $display("reset asserted at bit 7 of slot 3, released");
        run_slot(vc, idle_v(), 0);
        run_slot(idle_v(), vc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
